or_gate_arb: RTL and testbench



---
 rtl/or_gate_arb.sv | 134 +++++++++++++
 tb/tb_or_gate_arb.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/or_gate_arb.sv
// or_gate_arb: round-robin arbiter and one-slot output register.
//
// Collects the per-channel results of the OR-gate stage (NUM channels, BITS
// wide each, each with its own valid/ready) and serialises them onto a single
// registered valid/ready stream tagged with the source channel index.
//
// Parameters:
//   NUM      - number of input channels (2..16)
//   BITS     - data width per channel
//   CNT_BITS - width of the accepted-beat counter (wraps, no saturation)
//
// Ports:
//   clk       - clock, all state on the rising edge
//   rst_n     - asynchronous active-low reset
//   in_data   - channel k at [k*BITS +: BITS]
//   in_valid  - per-channel beat available
//   in_ready  - per-channel beat accepted this cycle (combinational)
//   out_data  - registered data of the selected beat
//   out_src   - channel index the registered beat came from
//   out_valid - output slot holds a beat
//   out_ready - downstream accepts the beat
//   beat_cnt  - accepted input beats since reset
module or_gate_arb #(
  parameter int unsigned NUM      = 4,
  parameter int unsigned BITS     = 32,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM*BITS-1:0]     in_data,
  input  logic [NUM-1:0]          in_valid,
  output logic [NUM-1:0]          in_ready,
  output logic [BITS-1:0]         out_data,
  output logic [$clog2(NUM)-1:0]  out_src,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_BITS-1:0]     beat_cnt
);

  localparam int unsigned SrcW = $clog2(NUM);

  logic [SrcW-1:0]     ptr_q, ptr_d;
  logic                out_valid_q, out_valid_d;
  logic [BITS-1:0]     out_data_q, out_data_d;
  logic [SrcW-1:0]     out_src_q, out_src_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  logic [NUM-1:0]  grant;
  logic [SrcW-1:0] gnt_idx;
  logic            gnt_any;
  logic [SrcW:0]   scan_sum;
  logic [SrcW-1:0] scan_idx;
  logic [BITS-1:0] sel_data;
  logic            load_ok;
  logic            accept;

  // Scan from ptr upward with wrap; first valid channel wins. The extra bit
  // in scan_sum holds ptr+i before the modulo-NUM fold.
  always_comb begin
    grant    = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    scan_sum = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < NUM; i++) begin
      scan_sum = {1'b0, ptr_q} + (SrcW+1)'(i);
      if (scan_sum >= (SrcW+1)'(NUM)) begin
        scan_sum = scan_sum - (SrcW+1)'(NUM);
      end
      scan_idx = scan_sum[SrcW-1:0];
      if (!gnt_any && in_valid[scan_idx]) begin
        gnt_any         = 1'b1;
        gnt_idx         = scan_idx;
        grant[scan_idx] = 1'b1;
      end
    end
  end

  // grant is one-hot or zero, so an OR of masked lanes is a clean mux.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < int'(NUM); k++) begin
      if (grant[k]) begin
        sel_data = sel_data | in_data[k*BITS +: BITS];
      end
    end
  end

  assign load_ok = !out_valid_q || out_ready;
  assign accept  = gnt_any && load_ok && rst_n;

  // Held off during reset so no upstream beat is consumed and then dropped.
  assign in_ready = grant & {NUM{load_ok & rst_n}};

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    cnt_d       = cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_src_d   = gnt_idx;
      ptr_d       = (gnt_idx == SrcW'(NUM-1)) ? '0 : gnt_idx + 1'b1;
      cnt_d       = cnt_q + 1'b1;
    end else if (out_valid_q && out_ready) begin
      // Drain with nothing new: data/src keep their last values.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      cnt_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_or_gate_arb.sv
// Self-checking bench for or_gate_arb: directed scenarios followed by a
// randomized stream, all compared against a transaction-level model.
module tb_or_gate_arb;

  localparam int unsigned NUM      = 4;
  localparam int unsigned BITS     = 32;
  localparam int unsigned CNT_BITS = 4;
  localparam int unsigned SW       = 2;
  localparam int unsigned CntMod   = 1 << CNT_BITS;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NUM*BITS-1:0] in_data;
  logic [NUM-1:0]      in_valid;
  logic [NUM-1:0]      in_ready;
  logic [BITS-1:0]     out_data;
  logic [SW-1:0]       out_src;
  logic                out_valid;
  logic                out_ready;
  logic [CNT_BITS-1:0] beat_cnt;

  or_gate_arb #(
    .NUM      (NUM),
    .BITS     (BITS),
    .CNT_BITS (CNT_BITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Upstream state: a channel's beat stays put until it is accepted.
  bit              tv[NUM];
  logic [BITS-1:0] td[NUM];

  // Model of the output slot, rotation pointer and beat counter.
  bit              m_valid;
  logic [BITS-1:0] m_data;
  int              m_src;
  int              m_ptr;
  int              m_cnt;
  int              last_g;

  task automatic apply_inputs(input bit rdy);
    out_ready = rdy;
    for (int k = 0; k < int'(NUM); k++) begin
      in_valid[k]               = tv[k];
      in_data[k*BITS +: BITS]   = td[k];
    end
  endtask

  task automatic set_valid(input logic [NUM-1:0] m);
    for (int k = 0; k < int'(NUM); k++) tv[k] = m[k];
  endtask

  // One clock cycle: drive, compare against the model, then advance it.
  task automatic cycle(input bit rdy);
    int             g;
    int             k;
    logic [NUM-1:0] exp_ready;
    @(negedge clk);
    apply_inputs(rdy);
    #1;
    g = -1;
    if (!m_valid || rdy) begin
      for (int i = 0; i < int'(NUM); i++) begin
        k = (m_ptr + i) % NUM;
        if (g < 0 && tv[k]) g = k;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("in_ready", in_ready, exp_ready);
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("out_data", out_data, m_data);
      check("out_src", out_src, m_src);
    end
    check("beat_cnt", beat_cnt, m_cnt % CntMod);
    @(posedge clk);
    last_g = g;
    if (g >= 0) begin
      m_valid = 1'b1;
      m_data  = td[g];
      m_src   = g;
      m_ptr   = (g + 1) % NUM;
      m_cnt++;
      tv[g]   = 1'b0;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
  endtask

  // Asynchronous reset held across one rising edge, released mid-cycle.
  task automatic reset_pulse(input bit rdy);
    apply_inputs(rdy);
    rst_n   = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = 0;
    m_ptr   = 0;
    m_cnt   = 0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_src", out_src, '0);
    check("rst_beat_cnt", beat_cnt, '0);
    check("rst_in_ready", in_ready, '0);
    @(posedge clk);
    #2;
    check("rst_hold_valid", out_valid, 1'b0);
    check("rst_hold_ready", in_ready, '0);
    rst_n = 1'b1;
  endtask

  initial begin
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b1;
    for (int k = 0; k < int'(NUM); k++) td[k] = 32'hA0 + k;
    set_valid(4'b1111);
    reset_pulse(1'b1);

    // Fair rotation with every channel valid.
    for (int i = 0; i < 8; i++) begin
      set_valid(4'b1111);
      cycle(1'b1);
      check("rot_grant", last_g, i % 4);
    end
    #1;
    check("rot_out_src", out_src, 3);
    check("rot_out_data", out_data, 32'hA3);
    check("rot_cnt", beat_cnt, 8);

    // Sparse: move ptr to 2 via channel 1, then 1 and 3 alternate.
    set_valid(4'b0010);
    cycle(1'b1);
    check("sp_first", last_g, 1);
    for (int i = 0; i < 4; i++) begin
      set_valid(4'b1010);
      cycle(1'b1);
      check("sp_grant", last_g, (i % 2 == 0) ? 3 : 1);
    end
    set_valid(4'b1000);
    cycle(1'b1);
    check("sp_ch3", last_g, 3);
    set_valid(4'b0010);
    cycle(1'b1);
    check("sp_wrap", last_g, 1);

    // Backpressure for 5 cycles, then release with no bubble.
    set_valid(4'b1111);
    cycle(1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0);
    cycle(1'b1);
    check("bp_resume", last_g >= 0, 1'b1);

    // Mid-stream reset with a held beat.
    set_valid(4'b1111);
    cycle(1'b0);
    #2;
    reset_pulse(1'b0);
    set_valid(4'b0110);
    cycle(1'b1);
    check("post_rst_grant", last_g, 1);

    // Randomized stream; also exercises beat_cnt wrap repeatedly.
    for (int n = 0; n < 2000; n++) begin
      for (int k = 0; k < int'(NUM); k++) begin
        if (!tv[k] && $urandom_range(0, 99) < 40) begin
          tv[k] = 1'b1;
          td[k] = $urandom;
        end
      end
      if ($urandom_range(0, 299) == 0) begin
        #2;
        reset_pulse($urandom_range(0, 1) == 1);
      end
      cycle($urandom_range(0, 99) < 70);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
